// File: rtl/cmem_mp.sv
// cmem_mp - multi-port coefficient memory with per-entry valid tracking,
// optional read-during-write bypass and an auto-incrementing burst loader.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   CEN, WEN            : active-low chip enable / direct write enable
//   CADDR, D            : direct write address and data
//   A, Q, Q_VLD         : NRD packed read addresses, registered data, valid flags
//   LD_START, LD_BASE,
//   LD_CNT              : burst request (base address and word count)
//   LD_VLD, LD_D        : burst data stream
//   LD_BUSY, LD_DONE    : loader active / one-cycle completion pulse
//   WR_DROP             : one-cycle pulse when a direct write loses to the loader
module cmem_mp #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     CEN,
    input  logic                     WEN,
    input  logic [ADDR_W-1:0]        CADDR,
    input  logic [DATA_W-1:0]        D,
    input  logic [NRD*ADDR_W-1:0]    A,
    output logic [NRD*DATA_W-1:0]    Q,
    output logic [NRD-1:0]           Q_VLD,
    input  logic                     LD_START,
    input  logic [ADDR_W-1:0]        LD_BASE,
    input  logic [ADDR_W:0]          LD_CNT,
    input  logic                     LD_VLD,
    input  logic [DATA_W-1:0]        LD_D,
    output logic                     LD_BUSY,
    output logic                     LD_DONE,
    output logic                     WR_DROP
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } ld_state_e;

    // True when the address maps onto a physical entry.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_C);
    endfunction

    ld_state_e              state_q;
    logic [ADDR_W-1:0]      ptr_q;
    logic [ADDR_W:0]        rem_q;
    logic                   ld_done_q;
    logic                   wr_drop_q;
    logic [DEPTH-1:0]       valid_q;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [NRD*DATA_W-1:0]  q_q, q_d;
    logic [NRD-1:0]         q_vld_q, q_vld_d;

    logic                   dir_req_s;
    logic                   ld_wr_s;
    logic                   wr_en_s;
    logic [ADDR_W-1:0]      wr_addr_s;
    logic [DATA_W-1:0]      wr_data_s;
    logic [ADDR_W-1:0]      rd_addr_s [NRD];

    // Single write port: the loader owns the array while busy, otherwise the
    // direct port. Writes are suppressed during reset so nothing lands in a
    // cycle whose valid update is being cleared.
    always_comb begin
        dir_req_s = !CEN && !WEN;
        ld_wr_s   = (state_q == ST_LOAD) && LD_VLD;
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        if (ld_wr_s) begin
            wr_en_s   = in_range(ptr_q) && !rst;
            wr_addr_s = ptr_q;
            wr_data_s = LD_D;
        end else if (dir_req_s && (state_q == ST_IDLE)) begin
            wr_en_s   = in_range(CADDR) && !rst;
            wr_addr_s = CADDR;
            wr_data_s = D;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Loader FSM: pointer/count tracking and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            ld_done_q <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (LD_START) begin
                        if (LD_CNT == '0) begin
                            // Empty burst completes immediately.
                            ld_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                            ptr_q   <= LD_BASE;
                            rem_q   <= LD_CNT;
                        end
                    end
                end
                ST_LOAD: begin
                    // LD_START is deliberately ignored here.
                    if (LD_VLD) begin
                        ptr_q <= (ptr_q == LAST_C) ? '0 : ptr_q + ADDR_W'(1);
                        rem_q <= rem_q - ONE_C;
                        if (rem_q == ONE_C) begin
                            state_q   <= ST_IDLE;
                            ld_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Direct write request that collided with an active burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= dir_req_s && (state_q == ST_LOAD);
        end
    end

    // Valid bitmap: cleared by reset, set by any accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_s) begin
            valid_q[wr_addr_s] <= 1'b1;
        end
    end

    // Storage array; contents survive reset and are masked by valid_q.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Unpack per-port read addresses.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_addr_s[k] = A[k*ADDR_W +: ADDR_W];
        end
    end

    // Next read data per port; unwritten or out-of-range entries read as zero.
    always_comb begin
        q_d     = q_q;
        q_vld_d = q_vld_q;
        if (!CEN) begin
            for (int k = 0; k < NRD; k++) begin
                if (!in_range(rd_addr_s[k])) begin
                    q_d[k*DATA_W +: DATA_W] = '0;
                    q_vld_d[k]              = 1'b0;
                end else if ((BYPASS != 0) && wr_en_s && (wr_addr_s == rd_addr_s[k])) begin
                    q_d[k*DATA_W +: DATA_W] = wr_data_s;
                    q_vld_d[k]              = 1'b1;
                end else if (valid_q[rd_addr_s[k]]) begin
                    q_d[k*DATA_W +: DATA_W] = mem_q[rd_addr_s[k]];
                    q_vld_d[k]              = 1'b1;
                end else begin
                    q_d[k*DATA_W +: DATA_W] = '0;
                    q_vld_d[k]              = 1'b0;
                end
            end
        end else begin
            q_d     = q_q;
            q_vld_d = q_vld_q;
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            q_vld_q <= '0;
        end else begin
            q_q     <= q_d;
            q_vld_q <= q_vld_d;
        end
    end

    assign Q       = q_q;
    assign Q_VLD   = q_vld_q;
    assign LD_BUSY = (state_q == ST_LOAD);
    assign LD_DONE = ld_done_q;
    assign WR_DROP = wr_drop_q;

endmodule
